// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and width helpers for the memory access sequencer.
package mem_pkg;

  localparam logic [2:0] MW_BYTE  = 3'b000;
  localparam logic [2:0] MW_HALF  = 3'b001;
  localparam logic [2:0] MW_WORD  = 3'b011;
  localparam logic [2:0] MW_DWORD = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StB0Req,
    StB0Wait,
    StB1Req,
    StB1Wait,
    StResp
  } mas_state_t;

  // Illegal width codes fall through to dword.
  function automatic logic [7:0] width_bytemask(input logic [2:0] width);
    unique case (width)
      MW_BYTE: width_bytemask = 8'h01;
      MW_HALF: width_bytemask = 8'h03;
      MW_WORD: width_bytemask = 8'h0F;
      default: width_bytemask = 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] width_nbytes(input logic [2:0] width);
    unique case (width)
      MW_BYTE: width_nbytes = 4'd1;
      MW_HALF: width_nbytes = 4'd2;
      MW_WORD: width_nbytes = 4'd4;
      default: width_nbytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Truncates merged load data to the access width and sign- or zero-extends it.
module mem_load_extend
  import mem_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic [2:0]   i_width,
  input  logic         i_signed,
  input  logic [N-1:0] i_data,
  output logic [N-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    unique case (i_width)
      MW_BYTE: o_data = {{(N-8){i_signed & i_data[7]}}, i_data[7:0]};
      MW_HALF: o_data = {{(N-16){i_signed & i_data[15]}}, i_data[15:0]};
      MW_WORD: o_data = {{(N-32){i_signed & i_data[31]}}, i_data[31:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Turns MEM-stage loads/stores into aligned 64-bit memory beats and returns one response each.
// Build option MEM_MISALIGN_SPLIT_EN: split doubleword-crossing accesses into two beats.
module mem_access_sequencer
  import mem_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic         i_req_write,
  input  logic         i_req_signed,
  input  logic [2:0]   i_req_width,
  input  logic [N-1:0] i_req_addr,
  input  logic [N-1:0] i_req_wdata,
  output logic         o_dm_valid,
  input  logic         i_dm_ready,
  output logic         o_dm_we,
  output logic [N-1:0] o_dm_addr,
  output logic [7:0]   o_dm_be,
  output logic [N-1:0] o_dm_wdata,
  input  logic         i_dm_rvalid,
  input  logic [N-1:0] i_dm_rdata,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [N-1:0] o_rsp_data,
  output logic         o_rsp_err
);

  mas_state_t r_state, w_state_next;

  logic         r_write;
  logic         r_signed;
  logic [2:0]   r_width;
  logic [N-1:0] r_addr;
  logic [N-1:0] r_wdata;
  logic [N-1:0] r_rdata;
  logic         r_err;
`ifdef MEM_MISALIGN_SPLIT_EN
  logic         r_cross;
`endif

  logic [2:0]     w_req_off;
  logic [2:0]     w_off;
  logic           w_req_cross;
  logic           w_accept;
  logic           w_req_ready;
  logic           w_dm_valid;
  logic           w_rsp_valid;
  logic           w_beat1;
  logic [15:0]    w_be_wide;
  logic [2*N-1:0] w_wdata_wide;
  logic [N-1:0]   w_base;
  logic [N-1:0]   w_ext;

  assign w_req_off   = i_req_addr[2:0];
  assign w_req_cross = ({1'b0, w_req_off} + width_nbytes(i_req_width)) > 4'd8;
  assign w_accept    = i_req_valid && (r_state == StIdle);

  // Low half of each wide shift is beat 0, high half is the spill into beat 1.
  assign w_off        = r_addr[2:0];
  assign w_base       = {r_addr[N-1:3], 3'b000};
  assign w_be_wide    = {8'h00, width_bytemask(r_width)} << w_off;
  assign w_wdata_wide = {{N{1'b0}}, r_wdata} << {w_off, 3'b000};
  assign w_beat1      = (r_state == StB1Req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_width  <= MW_BYTE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
`ifdef MEM_MISALIGN_SPLIT_EN
      r_cross  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_write  <= i_req_write;
        r_signed <= i_req_signed;
        r_width  <= i_req_width;
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
        r_rdata  <= '0;
`ifdef MEM_MISALIGN_SPLIT_EN
        r_cross  <= w_req_cross;
        r_err    <= 1'b0;
`else
        r_err    <= w_req_cross;
`endif
      end
      if ((r_state == StB0Wait) && i_dm_rvalid) begin
        r_rdata <= i_dm_rdata >> {w_off, 3'b000};
      end
`ifdef MEM_MISALIGN_SPLIT_EN
      if ((r_state == StB1Wait) && i_dm_rvalid) begin
        r_rdata <= r_rdata | (i_dm_rdata << {4'd8 - {1'b0, w_off}, 3'b000});
      end
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_dm_valid   = 1'b0;
    w_rsp_valid  = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_req_ready = 1'b1;
        if (i_req_valid) begin
`ifdef MEM_MISALIGN_SPLIT_EN
          w_state_next = StB0Req;
`else
          w_state_next = w_req_cross ? StResp : StB0Req;
`endif
        end
      end
      StB0Req: begin
        w_dm_valid = 1'b1;
        if (i_dm_ready) begin
`ifdef MEM_MISALIGN_SPLIT_EN
          if (!r_write)     w_state_next = StB0Wait;
          else if (r_cross) w_state_next = StB1Req;
          else              w_state_next = StResp;
`else
          w_state_next = r_write ? StResp : StB0Wait;
`endif
        end
      end
      StB0Wait: begin
        if (i_dm_rvalid) begin
`ifdef MEM_MISALIGN_SPLIT_EN
          w_state_next = r_cross ? StB1Req : StResp;
`else
          w_state_next = StResp;
`endif
        end
      end
`ifdef MEM_MISALIGN_SPLIT_EN
      StB1Req: begin
        w_dm_valid = 1'b1;
        if (i_dm_ready) w_state_next = r_write ? StResp : StB1Wait;
      end
      StB1Wait: begin
        if (i_dm_rvalid) w_state_next = StResp;
      end
`endif
      StResp: begin
        w_rsp_valid = 1'b1;
        if (i_rsp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  mem_load_extend #(
    .N(N)
  ) u_load_extend (
    .i_width  (r_width),
    .i_signed (r_signed),
    .i_data   (r_rdata),
    .o_data   (w_ext)
  );

  assign o_req_ready = w_req_ready;
  assign o_dm_valid  = w_dm_valid;
  assign o_dm_we     = w_dm_valid & r_write;
  assign o_dm_addr   = !w_dm_valid ? '0 : (w_beat1 ? w_base + N'(8) : w_base);
  assign o_dm_be     = !w_dm_valid ? '0 : (w_beat1 ? w_be_wide[15:8] : w_be_wide[7:0]);
  assign o_dm_wdata  = !(w_dm_valid && r_write) ? '0 :
                       (w_beat1 ? w_wdata_wide[2*N-1:N] : w_wdata_wide[N-1:0]);
  assign o_rsp_valid = w_rsp_valid;
  assign o_rsp_data  = (w_rsp_valid && !r_write && !r_err) ? w_ext : '0;
  assign o_rsp_err   = w_rsp_valid & r_err;

endmodule
